// File: rtl/bch_codeword_fetcher_if.sv
// bch_codeword_fetcher_if
//   Bundles the two buses the codeword fetcher sequences: the synchronous
//   helper-data memory read port and the BCH decoder start/result handshake.
//
//   Handshake semantics (both buses):
//     memory : O_mem_rd is a one-cycle read strobe qualified with O_mem_addr;
//              the memory presents I_mem_data one cycle after the edge that
//              sampled the strobe, and holds it until the next strobe.
//     decoder: O_dec_start is a one-cycle pulse that qualifies O_dec_data;
//              O_dec_data stays stable until the next codeword is packed.
//              I_dec_ready is the decoder's valid for I_dec_data; the fetcher
//              is always ready while waiting, so a beat transfers on any edge
//              where I_dec_ready is high and the fetcher is waiting.
//
//   Modports:
//     master : the fetcher (drives address/strobe/start/codeword)
//     slave  : memory + decoder side
interface bch_codeword_fetcher_if #(
  parameter int CODE_BITS = 15,
  parameter int DATA_BITS = 5,
  parameter int MEM_AD_B  = 5,
  parameter int MEM_DA_B  = 8
);
  logic [MEM_AD_B-1:0]  O_mem_addr;
  logic                 O_mem_rd;
  logic [MEM_DA_B-1:0]  I_mem_data;
  logic                 O_dec_start;
  logic [CODE_BITS-1:0] O_dec_data;
  logic [DATA_BITS-1:0] I_dec_data;
  logic                 I_dec_ready;

  modport master (
    output O_mem_addr, O_mem_rd, O_dec_start, O_dec_data,
    input  I_mem_data, I_dec_data, I_dec_ready
  );

  modport slave (
    input  O_mem_addr, O_mem_rd, O_dec_start, O_dec_data,
    output I_mem_data, I_dec_data, I_dec_ready
  );
endinterface

// File: rtl/bch_codeword_fetcher.sv
// bch_codeword_fetcher
//   Reads NUM_CW two-byte codewords from the helper-data memory, packs each
//   into a CODE_BITS word, starts the BCH decoder, waits for its result and
//   assembles the corrected DATA_BITS slices into O_key.
//
//   Optional feature macro: BCH_FETCH_RESP_XOR_EN
//     defined   : adds I_resp / O_resp_idx; packed word is XORed with I_resp
//                 (code-offset reconstruction) before driving the decoder.
//     undefined : packed word goes straight to the decoder.
//
//   Ports:
//     I_clk, I_rst_n : clock (rising edge), asynchronous active-low reset
//     I_en           : clock enable, low freezes all state and gates strobes
//     I_start        : begin a key fetch (honoured in IDLE and DONE only)
//     bus            : memory read port + decoder handshake (master side)
//     O_key          : assembled key, slice k written on decoder ready
//     O_busy         : high outside IDLE/DONE
//     O_done         : high in DONE
//     dbg_state      : current FSM state encoding
module bch_codeword_fetcher #(
  parameter int CODE_BITS = 15,
  parameter int DATA_BITS = 5,
  parameter int NUM_CW    = 4,
  parameter int MEM_AD_B  = 5,
  parameter int MEM_DA_B  = 8
) (
  input  logic                            I_clk,
  input  logic                            I_rst_n,
  input  logic                            I_en,
  input  logic                            I_start,
`ifdef BCH_FETCH_RESP_XOR_EN
  input  logic [CODE_BITS-1:0]            I_resp,
  output logic [((NUM_CW > 1) ? $clog2(NUM_CW) : 1)-1:0] O_resp_idx,
`endif
  bch_codeword_fetcher_if.master          bus,
  output logic [NUM_CW*DATA_BITS-1:0]     O_key,
  output logic                            O_busy,
  output logic                            O_done,
  output logic [2:0]                      dbg_state
);

  localparam int KW   = (NUM_CW > 1) ? $clog2(NUM_CW) : 1;
  localparam int HI_B = CODE_BITS - MEM_DA_B;
  localparam int AW   = KW + 1 + MEM_AD_B;
  localparam logic [KW-1:0] LAST_K = KW'(NUM_CW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAP   = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t               state;
  logic [KW-1:0]        k;
  logic [MEM_DA_B-1:0]  lo_q;
  logic [MEM_AD_B-1:0]  addr_q;
  logic                 rd_q;
  logic                 dec_start_q;
  logic [CODE_BITS-1:0] dec_data_q;
  logic [CODE_BITS-1:0] cw_raw;
  logic [CODE_BITS-1:0] cw_word;

  // Byte address of codeword kk: {kk, half}, zero-extended or truncated.
  function automatic logic [MEM_AD_B-1:0] cw_addr(input logic [KW-1:0] kk,
                                                  input logic half);
    logic [AW-1:0] wide;
    wide = AW'({kk, half});
    return wide[MEM_AD_B-1:0];
  endfunction

  // High byte arrives on the bus in CAP; only its low HI_B bits are used.
  assign cw_raw = {bus.I_mem_data[HI_B-1:0], lo_q};

`ifdef BCH_FETCH_RESP_XOR_EN
  assign cw_word    = cw_raw ^ I_resp;
  assign O_resp_idx = k;
`else
  assign cw_word    = cw_raw;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= S_IDLE;
      k           <= '0;
      lo_q        <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      dec_start_q <= 1'b0;
      dec_data_q  <= '0;
      O_key       <= '0;
      O_busy      <= 1'b0;
      O_done      <= 1'b0;
    end else if (I_en) begin
      dec_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_start) begin
            state  <= S_RD_LO;
            addr_q <= cw_addr(k, 1'b0);
            rd_q   <= 1'b1;
            O_busy <= 1'b1;
          end
        end
        S_RD_LO: begin
          state  <= S_RD_HI;
          addr_q <= cw_addr(k, 1'b1);
          rd_q   <= 1'b1;
        end
        S_RD_HI: begin
          // Low byte requested in RD_LO is on the bus now.
          state <= S_CAP;
          lo_q  <= bus.I_mem_data;
          rd_q  <= 1'b0;
        end
        S_CAP: begin
          state       <= S_START;
          dec_data_q  <= cw_word;
          dec_start_q <= 1'b1;
        end
        S_START: begin
          // Ready during the start cycle belongs to no request; skip it.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.I_dec_ready) begin
            for (int i = 0; i < NUM_CW; i++) begin
              if (k == KW'(i)) O_key[i*DATA_BITS +: DATA_BITS] <= bus.I_dec_data;
            end
            if (k == LAST_K) begin
              state  <= S_DONE;
              O_busy <= 1'b0;
              O_done <= 1'b1;
            end else begin
              state  <= S_RD_LO;
              k      <= k + KW'(1);
              addr_q <= cw_addr(k + KW'(1), 1'b0);
              rd_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (I_start) begin
            state  <= S_RD_LO;
            k      <= '0;
            O_key  <= '0;
            addr_q <= cw_addr('0, 1'b0);
            rd_q   <= 1'b1;
            O_busy <= 1'b1;
            O_done <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          rd_q   <= 1'b0;
          O_busy <= 1'b0;
          O_done <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are gated so a frozen sequencer never issues a read or a start.
  assign bus.O_mem_rd    = rd_q & I_en;
  assign bus.O_dec_start = dec_start_q & I_en;
  assign bus.O_mem_addr  = addr_q;
  assign bus.O_dec_data  = dec_data_q;
  assign dbg_state       = state;

endmodule
